// File: rtl/fifo_to_mem_if.sv
// FIFO-read and memory-write signal bundle between the capture engine and its FIFO/memory controller.
// Master side is the capture engine: it pops the FIFO and issues burst-of-2 writes.
interface fifo_to_mem_if #(
  parameter int FIFO_DATA_WIDTH = 72,
  parameter int MEM_ADDR_WIDTH  = 19,
  parameter int MEM_DATA_WIDTH  = 36,
  parameter int MEM_BW_WIDTH    = 4
);
  logic                       fifo_rd_en;
  logic [FIFO_DATA_WIDTH-1:0] fifo_data;
  logic                       fifo_empty;
  logic                       mem_w_n;
  logic                       mem_wr_full;
  logic [MEM_ADDR_WIDTH-1:0]  mem_ad_wr;
  logic [MEM_DATA_WIDTH-1:0]  mem_dwl;
  logic [MEM_DATA_WIDTH-1:0]  mem_dwh;
  logic [MEM_BW_WIDTH-1:0]    mem_bwl_n;
  logic [MEM_BW_WIDTH-1:0]    mem_bwh_n;

  modport master (
    output fifo_rd_en,
    input  fifo_data,
    input  fifo_empty,
    output mem_w_n,
    input  mem_wr_full,
    output mem_ad_wr,
    output mem_dwl,
    output mem_dwh,
    output mem_bwl_n,
    output mem_bwh_n
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_data,
    output fifo_empty,
    input  mem_w_n,
    output mem_wr_full,
    input  mem_ad_wr,
    input  mem_dwl,
    input  mem_dwh,
    input  mem_bwl_n,
    input  mem_bwh_n
  );
endinterface

// File: rtl/fifo_to_mem.sv
// Drains a FWFT FIFO into sequential memory writes; pop in cycle N, write presented in N+1, one per cycle.
// Stalls losslessly on empty FIFO, full memory queue or missing calibration; stops at the address limit.
module fifo_to_mem #(
  parameter int FIFO_DATA_WIDTH  = 72,
  parameter int MEM_ADDR_WIDTH   = 19,
  parameter int MEM_DATA_WIDTH   = 36,
  parameter int MEM_BW_WIDTH     = 4,
  parameter int MEM_BURST_LENGTH = 2,
  parameter int MEM_ADDR_LOW     = 0,
  parameter int MEM_ADDR_HIGH    = 2**MEM_ADDR_WIDTH - 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  fifo_to_mem_if.master             bus,
  input  logic                      start_capture,
  input  logic                      sw_rst,
  input  logic                      cal_done,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_high,
  output logic                      capture_done,
  output logic                      mem_full
);

  localparam int AW1 = MEM_ADDR_WIDTH + 1;
  localparam logic [MEM_ADDR_WIDTH:0] ADDR_LO = AW1'(MEM_ADDR_LOW);
  localparam logic [MEM_ADDR_WIDTH:0] ADDR_HI = AW1'(MEM_ADDR_HIGH);

  if (MEM_BURST_LENGTH != 2) begin : g_bad_burst
    $error("fifo_to_mem: MEM_BURST_LENGTH must be 2");
  end
  if (FIFO_DATA_WIDTH != 2 * MEM_DATA_WIDTH) begin : g_bad_width
    $error("fifo_to_mem: FIFO_DATA_WIDTH must be 2*MEM_DATA_WIDTH");
  end
  if (MEM_ADDR_HIGH < MEM_ADDR_LOW || MEM_ADDR_HIGH > 2**MEM_ADDR_WIDTH - 1) begin : g_bad_range
    $error("fifo_to_mem: address range invalid");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_DATA_WIDTH-1:0] dwh;
    logic [MEM_DATA_WIDTH-1:0] dwl;
  } wr_cmd_t;

  state_t                  state;
  logic [MEM_ADDR_WIDTH:0] wr_addr;
  wr_cmd_t                 wr_cmd;
  logic                    wr_n;
  logic                    slot;

  // One extra address bit lets wr_addr reach MEM_ADDR_HIGH+1 without wrapping.
  always_comb begin
    slot = rst_n && !sw_rst && (state == S_CAPTURE) && start_capture && cal_done &&
           !bus.fifo_empty && !bus.mem_wr_full && (wr_addr <= ADDR_HI);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || sw_rst) begin
      state        <= S_IDLE;
      wr_addr      <= ADDR_LO;
      wr_n         <= 1'b1;
      wr_cmd       <= '0;
      capture_done <= 1'b0;
      mem_full     <= 1'b0;
    end else begin
      wr_n <= !slot;
      if (slot) begin
        wr_cmd.addr <= wr_addr[MEM_ADDR_WIDTH-1:0];
        wr_cmd.dwh  <= bus.fifo_data[FIFO_DATA_WIDTH-1:MEM_DATA_WIDTH];
        wr_cmd.dwl  <= bus.fifo_data[MEM_DATA_WIDTH-1:0];
        wr_addr     <= wr_addr + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start_capture && cal_done) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (!start_capture) begin
            state        <= S_DONE;
            capture_done <= 1'b1;
          end else if (slot && (wr_addr == ADDR_HI)) begin
            state        <= S_DONE;
            capture_done <= 1'b1;
            mem_full     <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.fifo_rd_en = slot;
  assign bus.mem_w_n    = wr_n;
  assign bus.mem_ad_wr  = wr_cmd.addr;
  assign bus.mem_dwh    = wr_cmd.dwh;
  assign bus.mem_dwl    = wr_cmd.dwl;
  assign bus.mem_bwl_n  = {MEM_BW_WIDTH{1'b0}};
  assign bus.mem_bwh_n  = {MEM_BW_WIDTH{1'b0}};
  assign mem_addr_high  = wr_addr[MEM_ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_to_mem.sv
// Bench for fifo_to_mem: queue-based FIFO and capture model checked every cycle, plus directed scenarios.
module tb_fifo_to_mem;
  localparam int FDW  = 72;
  localparam int AW   = 4;
  localparam int DW   = 36;
  localparam int BW   = 4;
  localparam int LOW  = 0;
  localparam int HIGH = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, sw_rst, start_capture, cal_done;
  logic [AW-1:0] mem_addr_high;
  logic          capture_done, mem_full;

  fifo_to_mem_if #(.FIFO_DATA_WIDTH(FDW), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW),
                   .MEM_BW_WIDTH(BW)) bus ();

  fifo_to_mem #(
    .FIFO_DATA_WIDTH(FDW), .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .MEM_BW_WIDTH(BW),
    .MEM_BURST_LENGTH(2), .MEM_ADDR_LOW(LOW), .MEM_ADDR_HIGH(HIGH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .start_capture(start_capture), .sw_rst(sw_rst),
    .cal_done(cal_done), .mem_addr_high(mem_addr_high), .capture_done(capture_done),
    .mem_full(mem_full)
  );

  typedef struct {
    int             addr;
    logic [FDW-1:0] data;
  } wr_t;

  logic [FDW-1:0] fq[$];
  logic [FDW-1:0] pushed[$];
  wr_t            wlog[$];
  int             errors = 0;
  int             checks = 0;
  int             pops = 0;

  // Model: capture phase flags, next address, and the write expected on the bus this cycle.
  bit             m_cap, m_done, m_full, m_wr;
  int             m_addr, m_last_addr;
  logic [FDW-1:0] m_last_data;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FDW-1:0] rand_word();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[FDW-1:0];
  endfunction

  task automatic refresh();
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_data  = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic m_reset();
    m_cap = 0; m_done = 0; m_full = 0; m_wr = 0;
    m_addr = LOW; m_last_addr = 0; m_last_data = '0;
  endtask

  task automatic tick();
    bit slot, in_rst;
    @(negedge clk);
    in_rst = !rst_n || sw_rst;
    slot = !in_rst && m_cap && start_capture && cal_done && (fq.size() > 0) &&
           !bus.mem_wr_full && (m_addr <= HIGH);
    chk("fifo_rd_en", 128'(bus.fifo_rd_en), 128'(slot));
    chk("mem_w_n", 128'(bus.mem_w_n), 128'(!m_wr));
    chk("mem_ad_wr", 128'(bus.mem_ad_wr), 128'(m_last_addr[AW-1:0]));
    chk("mem_dwh", 128'(bus.mem_dwh), 128'(m_last_data[FDW-1:DW]));
    chk("mem_dwl", 128'(bus.mem_dwl), 128'(m_last_data[DW-1:0]));
    chk("mem_addr_high", 128'(mem_addr_high), 128'(m_addr[AW-1:0]));
    chk("capture_done", 128'(capture_done), 128'(m_done));
    chk("mem_full", 128'(mem_full), 128'(m_full));
    chk("byte_enables", 128'({bus.mem_bwh_n, bus.mem_bwl_n}), 128'(0));
    if (bus.mem_w_n === 1'b0) wlog.push_back('{addr: int'(bus.mem_ad_wr), data: {bus.mem_dwh, bus.mem_dwl}});
    @(posedge clk);
    if (in_rst) begin
      m_reset();
    end else begin
      m_wr = slot;
      if (slot) begin
        m_last_addr = m_addr;
        m_last_data = fq.pop_front();
        m_addr++;
        pops++;
      end
      if (m_cap) begin
        if (!start_capture) begin
          m_cap = 0; m_done = 1;
        end else if (slot && m_last_addr == HIGH) begin
          m_cap = 0; m_done = 1; m_full = 1;
        end
      end else if (!m_done && start_capture && cal_done) begin
        m_cap = 1;
      end
    end
    #1;
    refresh();
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      logic [FDW-1:0] w;
      w = rand_word();
      fq.push_back(w);
      pushed.push_back(w);
    end
    refresh();
  endtask

  task automatic clear_run(input bit use_rst_n);
    start_capture = 0;
    bus.mem_wr_full = 0;
    if (use_rst_n) rst_n = 0; else sw_rst = 1;
    tick();
    rst_n = 1; sw_rst = 0;
    fq.delete(); pushed.delete(); wlog.delete();
    pops = 0;
    refresh();
  endtask

  task automatic check_log(input string name, input int n, input int offset);
    chk({name, "_count"}, 128'(wlog.size()), 128'(n));
    for (int i = 0; i < n && i < wlog.size(); i++) begin
      chk({name, "_addr"}, 128'(wlog[i].addr), 128'(LOW + i));
      chk({name, "_data"}, 128'(wlog[i].data), 128'(pushed[offset + i]));
    end
  endtask

  initial begin
    rst_n = 0; sw_rst = 0; start_capture = 0; cal_done = 0;
    bus.mem_wr_full = 0;
    m_reset();
    refresh();
    @(posedge clk); #1;
    tick();
    chk("reset_w_n", 128'(bus.mem_w_n), 128'(1));
    chk("reset_addr_high", 128'(mem_addr_high), 128'(0));
    rst_n = 1;
    cal_done = 1;

    // Four preloaded words drain to addresses 0..3.
    push_words(4);
    start_capture = 1;
    repeat (8) tick();
    check_log("t1", 4, 0);
    chk("t1_addr_high", 128'(mem_addr_high), 128'(4));
    chk("t1_idle_w_n", 128'(bus.mem_w_n), 128'(1));
    clear_run(0);

    // Memory-queue full for three cycles mid-stream.
    push_words(6);
    start_capture = 1;
    repeat (3) tick();
    begin
      int n0;
      n0 = fq.size();
      bus.mem_wr_full = 1;
      repeat (3) tick();
      chk("t2_stall_fifo", 128'(fq.size()), 128'(n0));
      chk("t2_stall_pops", 128'(pops), 128'(2));
      bus.mem_wr_full = 0;
    end
    repeat (8) tick();
    check_log("t2", 6, 0);
    chk("t2_addr_high", 128'(mem_addr_high), 128'(6));
    clear_run(1);

    // Address limit: 10 queued, only 0..7 written.
    push_words(10);
    start_capture = 1;
    repeat (15) tick();
    check_log("t3", 8, 0);
    chk("t3_mem_full", 128'(mem_full), 128'(1));
    chk("t3_capture_done", 128'(capture_done), 128'(1));
    chk("t3_addr_high", 128'(mem_addr_high), 128'(8));
    chk("t3_fifo_left", 128'(fq.size()), 128'(2));
    clear_run(0);

    // start_capture dropped right after the third pop.
    push_words(6);
    start_capture = 1;
    for (int i = 0; i < 20 && pops < 3; i++) tick();
    chk("t4_pops_reached", 128'(pops), 128'(3));
    start_capture = 0;
    repeat (5) tick();
    check_log("t4", 3, 0);
    chk("t4_capture_done", 128'(capture_done), 128'(1));
    chk("t4_mem_full", 128'(mem_full), 128'(0));
    chk("t4_addr_high", 128'(mem_addr_high), 128'(3));
    clear_run(0);

    // sw_rst mid-capture, then restart from the low address with the remaining words.
    push_words(6);
    start_capture = 1;
    for (int i = 0; i < 20 && pops < 2; i++) tick();
    chk("t5_pops_reached", 128'(pops), 128'(2));
    sw_rst = 1;
    tick();
    sw_rst = 0;
    chk("t5_w_n", 128'(bus.mem_w_n), 128'(1));
    chk("t5_ad_wr", 128'(bus.mem_ad_wr), 128'(0));
    chk("t5_dwl", 128'(bus.mem_dwl), 128'(0));
    chk("t5_addr_high", 128'(mem_addr_high), 128'(0));
    chk("t5_fifo_kept", 128'(fq.size()), 128'(4));
    wlog.delete();
    repeat (10) tick();
    check_log("t5", 4, 2);
    clear_run(0);

    // Calibration not done: nothing moves until cal_done rises.
    cal_done = 0;
    push_words(3);
    start_capture = 1;
    repeat (5) tick();
    chk("t6_no_pop", 128'(fq.size()), 128'(3));
    chk("t6_no_write", 128'(wlog.size()), 128'(0));
    cal_done = 1;
    repeat (8) tick();
    check_log("t6", 3, 0);
    clear_run(0);

    // Randomised episodes against the cycle model.
    for (int ep = 0; ep < 30; ep++) begin
      clear_run(($urandom % 4) == 0);
      push_words($urandom_range(0, 5));
      start_capture = 1;
      for (int c = 0; c < 40; c++) begin
        if (($urandom % 2) == 0 && fq.size() < 12) push_words(1);
        bus.mem_wr_full = (($urandom % 4) == 0);
        cal_done = (($urandom % 8) != 0);
        if (($urandom % 60) == 0) start_capture = 0;
        sw_rst = (($urandom % 70) == 0);
        tick();
        sw_rst = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
